// File: rtl/mem_arbiter.sv
// mem_arbiter: shares one single-port word memory between an I-fetch
// port (read-only) and a D load/store port, one access per two cycles.
//
// Ports:
//   CLK, RESET               clock, synchronous active-high reset
//   i_req/i_addr             I request (held until i_ack)
//   i_ack/i_rdata            I completion pulse, registered read data
//   d_req/d_we/d_addr/d_wdata D request (held until d_ack)
//   d_ack/d_rdata            D completion pulse, registered read data
//                            (for stores: the word before the write)
//   mem_addr/mem_wd/mem_we   to memory; mem_rd combinational read back
//   busy                     high while the response cycle is in progress
// Optional: define MEM_ARB_STATS_EN to add saturating grant counters
//   i_grants[31:0] and d_grants[31:0].
module mem_arbiter #(
  parameter int ADDR_W   = 32,
  parameter int DATA_W   = 32,
  parameter int MAX_WAIT = 3
) (
  input  logic              CLK,
  input  logic              RESET,
  input  logic              i_req,
  input  logic [ADDR_W-1:0] i_addr,
  output logic              i_ack,
  output logic [DATA_W-1:0] i_rdata,
  input  logic              d_req,
  input  logic              d_we,
  input  logic [ADDR_W-1:0] d_addr,
  input  logic [DATA_W-1:0] d_wdata,
  output logic              d_ack,
  output logic [DATA_W-1:0] d_rdata,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wd,
  output logic              mem_we,
  input  logic [DATA_W-1:0] mem_rd,
  output logic              busy
`ifdef MEM_ARB_STATS_EN
  ,
  output logic [31:0]       i_grants,
  output logic [31:0]       d_grants
`endif
);

  localparam int WC_W = (MAX_WAIT > 0) ? $clog2(MAX_WAIT + 1) : 1;

  typedef enum logic {
    S_IDLE,
    S_RESP
  } state_t;

  state_t            r_state;
  logic [WC_W-1:0]   r_wait;
  logic              r_i_ack;
  logic              r_d_ack;
  logic [DATA_W-1:0] r_i_rdata;
  logic [DATA_W-1:0] r_d_rdata;
  logic              r_busy;

  logic              w_idle;
  logic              w_d_pri;
  logic              w_gnt_d;
  logic              w_gnt_i;
  logic [ADDR_W-1:0] w_addr;
  logic [DATA_W-1:0] w_wd;

  assign w_idle  = (r_state == S_IDLE);
  // D keeps priority on a tie until I has lost MAX_WAIT times in a row
  assign w_d_pri = (int'(r_wait) < MAX_WAIT);
  assign w_gnt_d = w_idle & d_req & (~i_req | w_d_pri);
  assign w_gnt_i = w_idle & i_req & ~w_gnt_d;

  always_comb begin
    w_addr = '0;
    w_wd   = '0;
    unique case (1'b1)
      w_gnt_d: begin
        w_addr = d_addr;
        w_wd   = d_wdata;
      end
      w_gnt_i: w_addr = i_addr;
      default: ;
    endcase
  end

  assign mem_addr = w_addr;
  assign mem_wd   = w_wd;
  // RESET blocks the write even though the grant itself is combinational
  assign mem_we   = w_gnt_d & d_we & ~RESET;

  always_ff @(posedge CLK) begin
    if (RESET) begin
      r_state   <= S_IDLE;
      r_wait    <= '0;
      r_i_ack   <= 1'b0;
      r_d_ack   <= 1'b0;
      r_i_rdata <= '0;
      r_d_rdata <= '0;
      r_busy    <= 1'b0;
    end else begin
      unique case (r_state)
        S_IDLE: begin
          if (w_gnt_d) begin
            r_d_rdata <= mem_rd;
            r_d_ack   <= 1'b1;
            r_busy    <= 1'b1;
            r_state   <= S_RESP;
            if (i_req && w_d_pri)
              r_wait <= r_wait + 1'b1;
          end else if (w_gnt_i) begin
            r_i_rdata <= mem_rd;
            r_i_ack   <= 1'b1;
            r_busy    <= 1'b1;
            r_state   <= S_RESP;
            r_wait    <= '0;
          end
        end
        S_RESP: begin
          r_i_ack <= 1'b0;
          r_d_ack <= 1'b0;
          r_busy  <= 1'b0;
          r_state <= S_IDLE;
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign i_ack   = r_i_ack;
  assign d_ack   = r_d_ack;
  assign i_rdata = r_i_rdata;
  assign d_rdata = r_d_rdata;
  assign busy    = r_busy;

`ifdef MEM_ARB_STATS_EN
  logic [31:0] r_i_grants;
  logic [31:0] r_d_grants;

  always_ff @(posedge CLK) begin
    if (RESET) begin
      r_i_grants <= '0;
      r_d_grants <= '0;
    end else begin
      if (w_gnt_i && r_i_grants != 32'hFFFF_FFFF)
        r_i_grants <= r_i_grants + 32'd1;
      if (w_gnt_d && r_d_grants != 32'hFFFF_FFFF)
        r_d_grants <= r_d_grants + 32'd1;
    end
  end

  assign i_grants = r_i_grants;
  assign d_grants = r_d_grants;
`endif

endmodule

// File: tb/tb_mem_arbiter.sv
// Bench for mem_arbiter: behavioural arbitration model plus directed
// vectors with literal expectations.
module tb_mem_arbiter;

  localparam int MW = 3;

  logic        CLK = 1'b0;
  logic        RESET = 1'b1;
  logic        i_req = 1'b0;
  logic [31:0] i_addr = '0;
  logic        i_ack;
  logic [31:0] i_rdata;
  logic        d_req = 1'b0;
  logic        d_we = 1'b0;
  logic [31:0] d_addr = '0;
  logic [31:0] d_wdata = '0;
  logic        d_ack;
  logic [31:0] d_rdata;
  logic [31:0] mem_addr;
  logic [31:0] mem_wd;
  logic        mem_we;
  logic [31:0] mem_rd;
  logic        busy;
`ifdef MEM_ARB_STATS_EN
  logic [31:0] i_grants;
  logic [31:0] d_grants;
  logic [31:0] z_i_grants;
  logic [31:0] z_d_grants;
`endif

  logic        z_i_req = 1'b0;
  logic [31:0] z_i_addr = '0;
  logic        z_i_ack;
  logic [31:0] z_i_rdata;
  logic        z_d_req = 1'b0;
  logic        z_d_we = 1'b0;
  logic [31:0] z_d_addr = '0;
  logic [31:0] z_d_wdata = '0;
  logic        z_d_ack;
  logic [31:0] z_d_rdata;
  logic [31:0] z_mem_addr;
  logic [31:0] z_mem_wd;
  logic        z_mem_we;
  logic [31:0] z_mem_rd;
  logic        z_busy;

  always #5 CLK = ~CLK;

  mem_arbiter #(.ADDR_W(32), .DATA_W(32), .MAX_WAIT(MW)) u_dut (
    .CLK(CLK), .RESET(RESET),
    .i_req(i_req), .i_addr(i_addr),
    .i_ack(i_ack), .i_rdata(i_rdata),
    .d_req(d_req), .d_we(d_we),
    .d_addr(d_addr), .d_wdata(d_wdata),
    .d_ack(d_ack), .d_rdata(d_rdata),
    .mem_addr(mem_addr), .mem_wd(mem_wd),
    .mem_we(mem_we), .mem_rd(mem_rd),
    .busy(busy)
`ifdef MEM_ARB_STATS_EN
    , .i_grants(i_grants), .d_grants(d_grants)
`endif
  );

  mem_arbiter #(.ADDR_W(32), .DATA_W(32), .MAX_WAIT(0)) u_z (
    .CLK(CLK), .RESET(RESET),
    .i_req(z_i_req), .i_addr(z_i_addr),
    .i_ack(z_i_ack), .i_rdata(z_i_rdata),
    .d_req(z_d_req), .d_we(z_d_we),
    .d_addr(z_d_addr), .d_wdata(z_d_wdata),
    .d_ack(z_d_ack), .d_rdata(z_d_rdata),
    .mem_addr(z_mem_addr), .mem_wd(z_mem_wd),
    .mem_we(z_mem_we), .mem_rd(z_mem_rd),
    .busy(z_busy)
`ifdef MEM_ARB_STATS_EN
    , .i_grants(z_i_grants), .d_grants(z_d_grants)
`endif
  );

  logic [31:0] mem [64];
  logic [31:0] ref_mem [64];

  assign mem_rd   = mem[mem_addr[7:2]];
  assign z_mem_rd = ~z_mem_addr;

  always @(posedge CLK)
    if (mem_we) mem[mem_addr[7:2]] <= mem_wd;

  int n_vec = 0;
  int n_err = 0;

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  // Model: one access at a time, response cycle after each grant,
  // I counts how many contended rounds it has lost.
  bit          m_resp = 0;
  int          m_wait = 0;
  bit          e_iack = 0;
  bit          e_dack = 0;
  bit          e_busy = 0;
  logic [31:0] e_ird = '0;
  logic [31:0] e_drd = '0;

  function automatic bit win_d();
    return !m_resp && d_req && (!i_req || m_wait < MW);
  endfunction

  function automatic bit win_i();
    return !m_resp && i_req && !win_d();
  endfunction

  initial forever begin
    @(posedge CLK);
    if (RESET) begin
      m_resp = 0; m_wait = 0;
      e_iack = 0; e_dack = 0; e_busy = 0;
      e_ird = '0; e_drd = '0;
    end else if (m_resp) begin
      m_resp = 0; e_iack = 0; e_dack = 0; e_busy = 0;
    end else if (win_d()) begin
      e_drd = ref_mem[d_addr[7:2]];
      if (d_we) ref_mem[d_addr[7:2]] = d_wdata;
      if (i_req) m_wait = m_wait + 1;
      e_dack = 1; e_busy = 1; m_resp = 1;
    end else if (win_i()) begin
      e_ird = ref_mem[i_addr[7:2]];
      m_wait = 0;
      e_iack = 1; e_busy = 1; m_resp = 1;
    end
  end

  bit    chk_en = 0;
  int    n_we = 0;
  int    z_ni = 0;
  int    z_nd = 0;
  int    z_nwe = 0;
  string glog = "";

  initial forever begin
    @(negedge CLK);
    if (chk_en) begin
      chk("i_ack", {31'b0, i_ack}, {31'b0, e_iack});
      chk("d_ack", {31'b0, d_ack}, {31'b0, e_dack});
      chk("i_rdata", i_rdata, e_ird);
      chk("d_rdata", d_rdata, e_drd);
      chk("busy", {31'b0, busy}, {31'b0, e_busy});
      chk("mem_we", {31'b0, mem_we},
          {31'b0, win_d() && d_we && !RESET});
      if (!m_resp)
        chk("mem_addr", mem_addr,
            win_d() ? d_addr : (win_i() ? i_addr : 32'h0));
      if (win_d())
        chk("mem_wd", mem_wd, d_wdata);
      chk("one_ack", {31'b0, i_ack & d_ack}, 32'h0);
      chk("z_one_ack", {31'b0, z_i_ack & z_d_ack}, 32'h0);
      if (i_ack) glog = {glog, "I"};
      if (d_ack) glog = {glog, "D"};
      if (mem_we) n_we++;
      if (z_i_ack) z_ni++;
      if (z_d_ack) z_nd++;
      if (z_mem_we) z_nwe++;
    end
  end

  task automatic tick();
    @(posedge CLK);
    #2;
  endtask

  task automatic wait_ack(input bit is_d);
    bit got = 0;
    for (int k = 0; k < 20 && !got; k++) begin
      @(negedge CLK);
      if (is_d ? d_ack : i_ack) got = 1;
    end
    chk(is_d ? "d_ack_timeout" : "i_ack_timeout", {31'b0, got}, 32'h1);
  endtask

  task automatic d_access(input bit we, input logic [31:0] a,
                          input logic [31:0] wd);
    d_req = 1; d_we = we; d_addr = a; d_wdata = wd;
    wait_ack(1);
    tick();
    d_req = 0; d_we = 0;
  endtask

  task automatic i_access(input logic [31:0] a);
    i_req = 1; i_addr = a;
    wait_ack(0);
    tick();
    i_req = 0;
  endtask

  initial begin
    int bad;
    for (int k = 0; k < 64; k++) begin
      mem[k] = 32'hA500_0000 | k;
      ref_mem[k] = 32'hA500_0000 | k;
    end
    mem[2] = 32'hDEAD_BEEF;
    ref_mem[2] = 32'hDEAD_BEEF;

    @(posedge CLK);
    chk_en = 1;
    repeat (2) @(posedge CLK);
    #2;
    // reset state
    chk("rst_i_rdata", i_rdata, 32'h0);
    chk("rst_busy", {31'b0, busy}, 32'h0);
    chk("rst_mem_we", {31'b0, mem_we}, 32'h0);

    // single I fetch
    RESET = 0; i_req = 1; i_addr = 32'h8;
    @(negedge CLK);
    chk("t1_c1_ack", {31'b0, i_ack}, 32'h0);
    chk("t1_addr", mem_addr, 32'h8);
    @(negedge CLK);
    chk("t1_c2_ack", {31'b0, i_ack}, 32'h1);
    chk("t1_c2_busy", {31'b0, busy}, 32'h1);
    chk("t1_rdata", i_rdata, 32'hDEAD_BEEF);
    tick();
    i_req = 0;
    @(negedge CLK);
    chk("t1_c3_ack", {31'b0, i_ack}, 32'h0);
    chk("t1_c3_busy", {31'b0, busy}, 32'h0);
    tick();

    // store then load back
    n_we = 0;
    d_access(1, 32'h10, 32'h1234_5678);
    chk("t2_st_old", d_rdata, 32'hA500_0004);
    d_access(0, 32'h10, 32'h0);
    chk("t2_ld", d_rdata, 32'h1234_5678);
    chk("t2_we_cycles", n_we, 32'd1);

    // sustained contention
    glog = "";
    i_addr = 32'h20; d_addr = 32'h24; d_we = 0;
    i_req = 1; d_req = 1;
    repeat (16) @(posedge CLK);
    #2;
    i_req = 0; d_req = 0;
    n_vec++;
    if (glog != "DDDIDDDI") begin
      n_err++;
      $display("FAIL grant_order: got %s expected DDDIDDDI", glog);
    end
    tick();

    // MAX_WAIT=0 instance: I wins every tie
    z_ni = 0; z_nd = 0; z_nwe = 0;
    z_i_addr = 32'h40; z_d_addr = 32'h44;
    z_d_we = 1; z_d_wdata = 32'h5555_AAAA;
    z_i_req = 1; z_d_req = 1;
    repeat (12) @(posedge CLK);
    #2;
    z_i_req = 0; z_d_req = 0;
    chk("t4_i_grants", z_ni, 32'd6);
    chk("t4_d_grants", z_nd, 32'd0);
    chk("t4_we", z_nwe, 32'd0);
    chk("t4_rdata", z_i_rdata, 32'hFFFF_FFBF);
    tick();

    // RESET during RESP
    i_req = 1; i_addr = 32'hC;
    @(posedge CLK);
    #2;
    RESET = 1; i_req = 0;
    @(negedge CLK);
    chk("t5_resp_ack", {31'b0, i_ack}, 32'h1);
    tick();
    chk("t5_rst_iack", {31'b0, i_ack}, 32'h0);
    chk("t5_rst_dack", {31'b0, d_ack}, 32'h0);
    chk("t5_rst_busy", {31'b0, busy}, 32'h0);
    chk("t5_rst_rdata", i_rdata, 32'h0);

    // RESET held with a pending store
    d_req = 1; d_we = 1; d_addr = 32'h14; d_wdata = 32'hBAD0_BAD0;
    @(negedge CLK);
    chk("t5_st_we", {31'b0, mem_we}, 32'h0);
    repeat (2) @(negedge CLK);
    tick();
    d_req = 0; d_we = 0; RESET = 0;
    chk("t5_st_mem", mem[5], 32'hA500_0005);
    chk("t5_busy", {31'b0, busy}, 32'h0);
    tick();

`ifdef MEM_ARB_STATS_EN
    RESET = 1;
    tick();
    RESET = 0;
    for (int k = 0; k < 5; k++) i_access(32'h4 * k);
    for (int k = 0; k < 2; k++) d_access(0, 32'h30, 32'h0);
    chk("t6_i_grants", i_grants, 32'd5);
    chk("t6_d_grants", d_grants, 32'd2);
    RESET = 1;
    tick();
    chk("t6_i_clr", i_grants, 32'd0);
    chk("t6_d_clr", d_grants, 32'd0);
    RESET = 0;
    tick();
`endif

    bad = 0;
    for (int k = 0; k < 64; k++)
      if (mem[k] !== ref_mem[k]) bad++;
    chk("mem_image", bad, 32'd0);

    chk_en = 0;
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
